// File: rtl/router_pkg.sv
// Shared router definitions: port count, port-index width and the per-output lock state.
// Used by the switch allocator and the credit manager.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index, and whether anything was picked.
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    idx,
  output logic                 found
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_W'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/credit_switch_allocator.sv
// Per-output wormhole switch allocator: round-robin over inputs, credit-gated, locked head..tail.
// Optional per-output stall watchdog enabled by defining SWALLOC_WDOG_EN.
module credit_switch_allocator
  import router_pkg::*;
#(
  parameter int WDOG_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_dest,
  input  logic [NUM_PORTS-1:0]          req_tail,
  input  logic [NUM_PORTS-1:0]          can_send,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*PORT_W-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]          stall_err
);

  // Handshake: a flit moves when req_valid[i] & grant[i] in the same cycle; grant is never
  // raised without req_valid, and an input may drop req_valid at any time without penalty.

  lock_state_t       state_q [NUM_PORTS];
  lock_state_t       state_d [NUM_PORTS];
  logic [PORT_W-1:0] owner_q [NUM_PORTS];
  logic [PORT_W-1:0] owner_d [NUM_PORTS];
  logic [PORT_W-1:0] ptr_q   [NUM_PORTS];
  logic [PORT_W-1:0] ptr_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig    [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  logic [PORT_W-1:0]    arb_idx [NUM_PORTS];
  logic                 arb_found [NUM_PORTS];
  logic [NUM_PORTS-1:0] fire;

  // A locked output only listens to its owner; dest values >= NUM_PORTS match no output.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = req_valid[i] && (req_dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
      elig[o] = (state_q[o] == LOCKED) ? (cand[o] & (NUM_PORTS'(1) << owner_q[o])) : cand[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req   (elig[o]),
      .ptr   (ptr_q[o]),
      .gnt   (arb_gnt[o]),
      .idx   (arb_idx[o]),
      .found (arb_found[o])
    );
  end

  always_comb begin
    fire      = '0;
    grant     = '0;
    out_valid = '0;
    xbar_sel  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      fire[o] = rst_n && arb_found[o] && can_send[o];
      if (fire[o]) begin
        out_valid[o]                  = 1'b1;
        grant                         = grant | arb_gnt[o];
        xbar_sel[o*PORT_W +: PORT_W]  = arb_idx[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (fire[o]) begin
        if (req_tail[arb_idx[o]]) begin
          state_d[o] = IDLE;
          ptr_d[o]   = (arb_idx[o] == PORT_W'(NUM_PORTS - 1)) ? '0 : arb_idx[o] + 1'b1;
        end else begin
          state_d[o] = LOCKED;
          owner_d[o] = arb_idx[o];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (!rst_n) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

`ifdef SWALLOC_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] err_q;
  logic [NUM_PORTS-1:0] err_d;

  // A stall is an output with work pending (candidate or held lock) but no credit.
  always_comb begin
    err_d = err_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      cnt_d[o] = cnt_q[o];
      if (can_send[o]) begin
        cnt_d[o] = '0;
      end else if ((|cand[o]) || (state_q[o] == LOCKED)) begin
        if (cnt_q[o] < CNT_W'(WDOG_CYCLES)) cnt_d[o] = cnt_q[o] + 1'b1;
      end else begin
        cnt_d[o] = '0;
      end
      if (cnt_d[o] == CNT_W'(WDOG_CYCLES)) err_d[o] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) cnt_q[o] <= '0;
    end else begin
      err_q <= err_d;
      for (int o = 0; o < NUM_PORTS; o++) cnt_q[o] <= cnt_d[o];
    end
  end

  assign stall_err = err_q;
`else
  // Watchdog absent: flag is constant zero (the threshold only matters for a bad negative value).
  assign stall_err = {NUM_PORTS{WDOG_CYCLES < 0}};
`endif

endmodule
